// File: rtl/junction_phase_scheduler.sv
// ---------------------------------------------------------------------------
// junction_phase_scheduler
//
// Timed phase scheduler for a 4-way junction (lanes a, b, c, d). One lane at
// a time is granted green. The green length scales with that lane's density
// reading. A starving lane is forced in, and emergency requests pre-empt
// normal service. Every hand-over goes through yellow and all-red clearance.
//
// Ports:
//   clock        - system clock, all logic on posedge
//   clear        - synchronous active-high reset, dominates everything
//   dens_a..d    - 3-bit lane density readings (0 = no traffic)
//   ss[3:0]      - level-sensitive emergency requests, ss[0]=a .. ss[3]=d
//   ID[11:0]     - lights, [11:9]=a [8:6]=b [5:3]=c [2:0]=d;
//                  per lane 100=red, 010=yellow, 001=green
//   active_lane  - lane currently or most recently granted (0=a .. 3=d)
//   phase        - 00 ALL_RED, 01 GREEN, 10 YELLOW, 11 EMERG_GREEN
//   emerg_active - high while in EMERG_GREEN
//   starve_grant - one-cycle pulse on the first cycle of a starvation grant
// ---------------------------------------------------------------------------
module junction_phase_scheduler #(
    parameter int MIN_GREEN    = 4,
    parameter int UNIT_GREEN   = 2,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int MAX_WAIT     = 32,
    parameter int TW           = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [2:0]  dens_a,
    input  logic [2:0]  dens_b,
    input  logic [2:0]  dens_c,
    input  logic [2:0]  dens_d,
    input  logic [3:0]  ss,
    output logic [11:0] ID,
    output logic [1:0]  active_lane,
    output logic [1:0]  phase,
    output logic        emerg_active,
    output logic        starve_grant
);

    typedef enum logic [1:0] {
        ALL_RED     = 2'b00,
        GREEN       = 2'b01,
        YELLOW      = 2'b10,
        EMERG_GREEN = 2'b11
    } phase_t;

    phase_t          phase_q, phase_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [TW-1:0]   green_cnt_q, green_cnt_d;
    logic [1:0]      active_lane_q, active_lane_d;
    logic [1:0]      last_lane_q, last_lane_d;
    logic [11:0]     id_q, id_d;
    logic            emerg_active_q, emerg_active_d;
    logic            starve_grant_q, starve_grant_d;
    logic [5:0]      wait_q [4];
    logic [5:0]      wait_d [4];

    logic [2:0]      dens [4];

    logic [1:0]      em_pick;
    logic            starve_found;
    logic [1:0]      starve_pick;
    logic [2:0]      max_dens;
    logic [1:0]      max_pick;
    logic [1:0]      idx;

    logic            do_grant;
    logic [1:0]      grant_lane;
    logic            enter_valid;
    logic [1:0]      enter_lane;
    logic [3:0]      other_ss;

    assign dens[0] = dens_a;
    assign dens[1] = dens_b;
    assign dens[2] = dens_c;
    assign dens[3] = dens_d;

    // Candidate selection for the ALL_RED decision point. Emergencies go to the
    // lowest requesting index. Starvation and max-density both walk the lanes
    // in round-robin order starting after the last granted lane. A strict
    // greater-than keeps the first lane in that order on density ties.
    always_comb begin
        em_pick      = 2'd0;
        starve_found = 1'b0;
        starve_pick  = 2'd0;
        max_dens     = 3'd0;
        max_pick     = 2'd0;
        idx          = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (ss[i]) em_pick = 2'(i);
        end
        for (int k = 1; k <= 4; k++) begin
            idx = last_lane_q + 2'(k);
            if (!starve_found && (wait_q[idx] >= 6'(MAX_WAIT)) && (dens[idx] != 3'd0)) begin
                starve_found = 1'b1;
                starve_pick  = idx;
            end
            if (dens[idx] > max_dens) begin
                max_dens = dens[idx];
                max_pick = idx;
            end
        end
    end

    // Phase sequencing. Timers count down to 1. The cycle with timer==1 is the
    // last cycle of the phase. An idle ALL_RED parks the timer at 0 and keeps
    // re-deciding. green_cnt tracks elapsed green cycles for the early exit.
    always_comb begin
        phase_d        = phase_q;
        timer_d        = timer_q;
        green_cnt_d    = green_cnt_q;
        active_lane_d  = active_lane_q;
        last_lane_d    = last_lane_q;
        starve_grant_d = 1'b0;
        do_grant       = 1'b0;
        grant_lane     = 2'd0;
        enter_valid    = 1'b0;
        enter_lane     = 2'd0;
        other_ss       = ss & ~(4'b0001 << active_lane_q);

        case (phase_q)
            ALL_RED: begin
                if (timer_q > TW'(1)) begin
                    timer_d = timer_q - TW'(1);
                end else if (ss != 4'd0) begin
                    phase_d       = EMERG_GREEN;
                    active_lane_d = em_pick;
                    timer_d       = '0;
                    enter_valid   = 1'b1;
                    enter_lane    = em_pick;
                end else if (starve_found) begin
                    do_grant       = 1'b1;
                    grant_lane     = starve_pick;
                    starve_grant_d = 1'b1;
                end else if (max_dens != 3'd0) begin
                    do_grant   = 1'b1;
                    grant_lane = max_pick;
                end else begin
                    timer_d = '0;
                end
            end
            GREEN: begin
                if (other_ss != 4'd0) begin
                    phase_d = YELLOW;
                    timer_d = TW'(YELLOW_TIME);
                end else if (ss[active_lane_q]) begin
                    phase_d     = EMERG_GREEN;
                    timer_d     = '0;
                    enter_valid = 1'b1;
                    enter_lane  = active_lane_q;
                end else if (timer_q <= TW'(1)) begin
                    phase_d = YELLOW;
                    timer_d = TW'(YELLOW_TIME);
                end else if ((green_cnt_q >= TW'(MIN_GREEN)) && (dens[active_lane_q] == 3'd0)) begin
                    phase_d = YELLOW;
                    timer_d = TW'(YELLOW_TIME);
                end else begin
                    timer_d = timer_q - TW'(1);
                    if (green_cnt_q < TW'(MIN_GREEN)) green_cnt_d = green_cnt_q + TW'(1);
                end
            end
            YELLOW: begin
                if (timer_q > TW'(1)) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    phase_d = ALL_RED;
                    timer_d = TW'(ALL_RED_TIME);
                end
            end
            EMERG_GREEN: begin
                if (!ss[active_lane_q]) begin
                    phase_d = YELLOW;
                    timer_d = TW'(YELLOW_TIME);
                end
            end
            default: begin
                phase_d = ALL_RED;
                timer_d = TW'(ALL_RED_TIME);
            end
        endcase

        if (do_grant) begin
            phase_d       = GREEN;
            active_lane_d = grant_lane;
            last_lane_d   = grant_lane;
            timer_d       = TW'(MIN_GREEN) + TW'(UNIT_GREEN) * TW'(dens[grant_lane]);
            green_cnt_d   = TW'(1);
            enter_valid   = 1'b1;
            enter_lane    = grant_lane;
        end
    end

    // Lights are decoded from the next state so they switch on the same edge.
    always_comb begin
        id_d           = 12'b100_100_100_100;
        emerg_active_d = (phase_d == EMERG_GREEN);
        for (int i = 0; i < 4; i++) begin
            if (2'(i) == active_lane_d) begin
                if (phase_d == GREEN || phase_d == EMERG_GREEN) begin
                    id_d[(3 - i) * 3 +: 3] = 3'b001;
                end else if (phase_d == YELLOW) begin
                    id_d[(3 - i) * 3 +: 3] = 3'b010;
                end
            end
        end
    end

    // Wait counters count cycles of unserved demand. They hold rather than
    // clear when demand disappears, so a lane that flickers keeps its credit.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wait_d[i] = wait_q[i];
            if (enter_valid && (enter_lane == 2'(i))) begin
                wait_d[i] = 6'd0;
            end else if ((dens[i] != 3'd0) &&
                         !(((phase_q == GREEN) || (phase_q == EMERG_GREEN)) && (active_lane_q == 2'(i))) &&
                         (wait_q[i] != 6'd63)) begin
                wait_d[i] = wait_q[i] + 6'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            phase_q        <= ALL_RED;
            timer_q        <= TW'(ALL_RED_TIME);
            green_cnt_q    <= '0;
            active_lane_q  <= 2'd0;
            last_lane_q    <= 2'd3;
            id_q           <= 12'b100_100_100_100;
            emerg_active_q <= 1'b0;
            starve_grant_q <= 1'b0;
            for (int i = 0; i < 4; i++) wait_q[i] <= 6'd0;
        end else begin
            phase_q        <= phase_d;
            timer_q        <= timer_d;
            green_cnt_q    <= green_cnt_d;
            active_lane_q  <= active_lane_d;
            last_lane_q    <= last_lane_d;
            id_q           <= id_d;
            emerg_active_q <= emerg_active_d;
            starve_grant_q <= starve_grant_d;
            for (int i = 0; i < 4; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign ID           = id_q;
    assign active_lane  = active_lane_q;
    assign phase        = phase_q;
    assign emerg_active = emerg_active_q;
    assign starve_grant = starve_grant_q;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// ---------------------------------------------------------------------------
// tb_junction_phase_scheduler
//
// Directed bench for junction_phase_scheduler with default parameters.
// Table records hold a set of inputs for n cycles and give the outputs
// expected after each of those edges. Hand-written sequences cover
// emergency hand-over and a reset during yellow.
// ---------------------------------------------------------------------------
module tb_junction_phase_scheduler;

    localparam logic [11:0] RED = 12'b100_100_100_100;
    localparam logic [11:0] GA  = 12'b001_100_100_100;
    localparam logic [11:0] YA  = 12'b010_100_100_100;
    localparam logic [11:0] GB  = 12'b100_001_100_100;
    localparam logic [11:0] YB  = 12'b100_010_100_100;
    localparam logic [11:0] GC  = 12'b100_100_001_100;
    localparam logic [11:0] YC  = 12'b100_100_010_100;
    localparam logic [11:0] GD  = 12'b100_100_100_001;
    localparam logic [11:0] YD  = 12'b100_100_100_010;

    logic        clock;
    logic        clear;
    logic [2:0]  dens_a, dens_b, dens_c, dens_d;
    logic [3:0]  ss;
    logic [11:0] ID;
    logic [1:0]  active_lane;
    logic [1:0]  phase;
    logic        emerg_active;
    logic        starve_grant;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          tag;
        logic        clr;
        logic [2:0]  da, db, dc, dd;
        logic [3:0]  s;
        int          n;
        logic [11:0] id;
        logic [1:0]  ph;
        logic [1:0]  lane;
        logic        em;
        logic        st;
    } vec_t;

    vec_t vecs[$];

    junction_phase_scheduler dut (
        .clock        (clock),
        .clear        (clear),
        .dens_a       (dens_a),
        .dens_b       (dens_b),
        .dens_c       (dens_c),
        .dens_d       (dens_d),
        .ss           (ss),
        .ID           (ID),
        .active_lane  (active_lane),
        .phase        (phase),
        .emerg_active (emerg_active),
        .starve_grant (starve_grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void addVector(input logic clr, input logic [2:0] da, input logic [2:0] db,
                                      input logic [2:0] dc, input logic [2:0] dd, input logic [3:0] s,
                                      input int n, input logic [11:0] id, input logic [1:0] ph,
                                      input logic [1:0] lane, input logic em, input logic st);
        vec_t v;
        v.tag = vecs.size();
        v.clr = clr; v.da = da; v.db = db; v.dc = dc; v.dd = dd; v.s = s;
        v.n = n; v.id = id; v.ph = ph; v.lane = lane; v.em = em; v.st = st;
        vecs.push_back(v);
    endfunction

    // Drive inputs for one cycle, then let the edge happen and settle.
    task automatic applyStimulus(input logic clr, input logic [2:0] da, input logic [2:0] db,
                                 input logic [2:0] dc, input logic [2:0] dd, input logic [3:0] s);
        clear  = clr;
        dens_a = da;
        dens_b = db;
        dens_c = dc;
        dens_d = dd;
        ss     = s;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [11:0] id,
                               input logic [1:0] ph, input logic [1:0] lane,
                               input logic em, input logic st);
        checks++;
        if (ID !== id || phase !== ph || active_lane !== lane ||
            emerg_active !== em || starve_grant !== st) begin
            failures++;
            $display("[TB] FAIL %s.%0d: got ID=%b phase=%b lane=%0d emerg=%b starve=%b, want ID=%b phase=%b lane=%0d emerg=%b starve=%b",
                     name, idx, ID, phase, active_lane, emerg_active, starve_grant,
                     id, ph, lane, em, st);
        end
    endtask

    initial begin
        clear = 1'b1; dens_a = 3'd0; dens_b = 3'd0; dens_c = 3'd0; dens_d = 3'd0; ss = 4'd0;

        // Lane b alone, density 3: red 2, green 10, yellow 3, red 2.
        addVector(1, 0,3,0,0, 4'h0, 1,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 0,3,0,0, 4'h0, 1,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 0,3,0,0, 4'h0, 10, GB,  2'b01, 2'd1, 0, 0);
        addVector(0, 0,3,0,0, 4'h0, 3,  YB,  2'b10, 2'd1, 0, 0);
        addVector(0, 0,3,0,0, 4'h0, 2,  RED, 2'b00, 2'd1, 0, 0);
        // a and c tied at 5: a first (after lane d), then c, 14 cycles each.
        addVector(1, 5,0,5,0, 4'h0, 1,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 5,0,5,0, 4'h0, 1,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 5,0,5,0, 4'h0, 14, GA,  2'b01, 2'd0, 0, 0);
        addVector(0, 5,0,5,0, 4'h0, 3,  YA,  2'b10, 2'd0, 0, 0);
        addVector(0, 5,0,5,0, 4'h0, 2,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 5,0,5,0, 4'h0, 14, GC,  2'b01, 2'd2, 0, 0);
        addVector(0, 5,0,5,0, 4'h0, 3,  YC,  2'b10, 2'd2, 0, 0);
        // Lane a green, ss[2] raised at green cycle 5 and held 8 cycles.
        addVector(1, 3,0,0,0, 4'h0, 1,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 3,0,0,0, 4'h0, 1,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 3,0,0,0, 4'h0, 5,  GA,  2'b01, 2'd0, 0, 0);
        addVector(0, 3,0,0,0, 4'h4, 3,  YA,  2'b10, 2'd0, 0, 0);
        addVector(0, 3,0,0,0, 4'h4, 2,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 3,0,0,0, 4'h4, 3,  GC,  2'b11, 2'd2, 1, 0);
        addVector(0, 3,0,0,0, 4'h0, 3,  YC,  2'b10, 2'd2, 0, 0);
        addVector(0, 3,0,0,0, 4'h0, 2,  RED, 2'b00, 2'd2, 0, 0);
        addVector(0, 3,0,0,0, 4'h0, 1,  GA,  2'b01, 2'd0, 0, 0);
        // a=7 dominates until d starves; d's counter must clear on grant.
        addVector(1, 7,0,0,1, 4'h0, 1,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 7,0,0,1, 4'h0, 1,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 7,0,0,1, 4'h0, 18, GA,  2'b01, 2'd0, 0, 0);
        addVector(0, 7,0,0,1, 4'h0, 3,  YA,  2'b10, 2'd0, 0, 0);
        addVector(0, 7,0,0,1, 4'h0, 2,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 7,0,0,1, 4'h0, 18, GA,  2'b01, 2'd0, 0, 0);
        addVector(0, 7,0,0,1, 4'h0, 3,  YA,  2'b10, 2'd0, 0, 0);
        addVector(0, 7,0,0,1, 4'h0, 2,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 7,0,0,1, 4'h0, 1,  GD,  2'b01, 2'd3, 0, 1);
        addVector(0, 7,0,0,1, 4'h0, 5,  GD,  2'b01, 2'd3, 0, 0);
        addVector(0, 7,0,0,1, 4'h0, 3,  YD,  2'b10, 2'd3, 0, 0);
        addVector(0, 7,0,0,1, 4'h0, 2,  RED, 2'b00, 2'd3, 0, 0);
        addVector(0, 7,0,0,1, 4'h0, 1,  GA,  2'b01, 2'd0, 0, 0);
        // Lane b density 4 drops to 0 at green cycle 2: green lasts 4 cycles.
        addVector(1, 0,4,0,0, 4'h0, 1,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 0,4,0,0, 4'h0, 1,  RED, 2'b00, 2'd0, 0, 0);
        addVector(0, 0,4,0,0, 4'h0, 2,  GB,  2'b01, 2'd1, 0, 0);
        addVector(0, 0,0,0,0, 4'h0, 2,  GB,  2'b01, 2'd1, 0, 0);
        addVector(0, 0,0,0,0, 4'h0, 3,  YB,  2'b10, 2'd1, 0, 0);
        addVector(0, 0,0,0,0, 4'h0, 5,  RED, 2'b00, 2'd1, 0, 0);

        foreach (vecs[v]) begin
            for (int c = 0; c < vecs[v].n; c++) begin
                applyStimulus(vecs[v].clr, vecs[v].da, vecs[v].db, vecs[v].dc, vecs[v].dd, vecs[v].s);
                checkOutput("vec", vecs[v].tag * 100 + c, vecs[v].id, vecs[v].ph,
                            vecs[v].lane, vecs[v].em, vecs[v].st);
            end
        end

        // Emergency on the green lane goes straight to EMERG_GREEN; a lower
        // index arriving mid-hold waits for the next ALL_RED decision.
        applyStimulus(1, 0,2,0,0, 4'h0); checkOutput("emerg", 0, RED, 2'b00, 2'd0, 0, 0);
        applyStimulus(0, 0,2,0,0, 4'h0); checkOutput("emerg", 1, RED, 2'b00, 2'd0, 0, 0);
        applyStimulus(0, 0,2,0,0, 4'h0); checkOutput("emerg", 2, GB,  2'b01, 2'd1, 0, 0);
        applyStimulus(0, 0,2,0,0, 4'h2); checkOutput("emerg", 3, GB,  2'b11, 2'd1, 1, 0);
        applyStimulus(0, 0,2,0,0, 4'h3); checkOutput("emerg", 4, GB,  2'b11, 2'd1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0,2,0,0, 4'h1); checkOutput("emerg", 5 + i, YB, 2'b10, 2'd1, 0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0,2,0,0, 4'h1); checkOutput("emerg", 8 + i, RED, 2'b00, 2'd1, 0, 0);
        end
        applyStimulus(0, 0,2,0,0, 4'h1); checkOutput("emerg", 10, GA, 2'b11, 2'd0, 1, 0);
        applyStimulus(0, 0,2,0,0, 4'h0); checkOutput("emerg", 11, YA, 2'b10, 2'd0, 0, 0);

        // Reset mid-yellow, then a clean restart with full all-red timing.
        applyStimulus(1, 0,0,1,0, 4'h0); checkOutput("midclr", 0, RED, 2'b00, 2'd0, 0, 0);
        applyStimulus(0, 0,0,1,0, 4'h0); checkOutput("midclr", 1, RED, 2'b00, 2'd0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0,0,1,0, 4'h0); checkOutput("midclr", 2 + i, GC, 2'b01, 2'd2, 0, 0);
        end
        applyStimulus(0, 0,0,1,0, 4'h0); checkOutput("midclr", 8, YC, 2'b10, 2'd2, 0, 0);
        applyStimulus(0, 0,0,1,0, 4'h0); checkOutput("midclr", 9, YC, 2'b10, 2'd2, 0, 0);
        applyStimulus(1, 0,0,1,0, 4'h0); checkOutput("midclr", 10, RED, 2'b00, 2'd0, 0, 0);
        applyStimulus(0, 0,0,1,0, 4'h0); checkOutput("midclr", 11, RED, 2'b00, 2'd0, 0, 0);
        applyStimulus(0, 0,0,1,0, 4'h0); checkOutput("midclr", 12, GC, 2'b01, 2'd2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
